// File: rtl/instr_mem_pipe_if.sv
// Fetch, response and program-load signals between the fetch stage and the instruction memory.
interface instr_mem_pipe_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic [ADDR_W-1:0] addr_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] instr_o;
  logic [1:0]        fault_o;
  logic              flush_i;
  logic              load_en_i;
  logic [ADDR_W-1:0] load_addr_i;
  logic [DATA_W-1:0] load_data_i;
  logic [31:0]       fetch_cnt_o;

  modport slave (
    input  req_valid_i, addr_i, rsp_ready_i, flush_i, load_en_i, load_addr_i, load_data_i,
    output req_ready_o, rsp_valid_o, instr_o, fault_o, fetch_cnt_o
  );

  modport master (
    output req_valid_i, addr_i, rsp_ready_i, flush_i, load_en_i, load_addr_i, load_data_i,
    input  req_ready_o, rsp_valid_o, instr_o, fault_o, fetch_cnt_o
  );
endinterface

// File: rtl/instr_mem_pipe.sv
// Synchronous-read instruction memory with a one-entry response register, fault
// classification, flush support and a program-load write port.
module instr_mem_pipe #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned ADDR_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(32'h0000_0013)
) (
  input logic               clk_i,
  input logic               rst_i,
  instr_mem_pipe_if.slave   bus
);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned WIDX_W = ADDR_W - 2;
  localparam logic [WIDX_W:0] DEPTH_EXT = (WIDX_W + 1)'(DEPTH);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] instr_q;
  logic [1:0]        fault_q;
  logic [31:0]       cnt_q;

  logic              ready_c, accept_c, load_rsp_c;
  logic              fetch_in_range_c, load_in_range_c;
  logic [1:0]        fault_c;
  logic [WIDX_W-1:0] fetch_idx_c, load_idx_c;
  logic              unused_load_lsb;

  // Byte offset of a load is meaningless for word-wide writes.
  assign unused_load_lsb = ^bus.load_addr_i[1:0];

  // Range checks use the full word index so aliased high addresses are rejected.
  assign fetch_idx_c      = bus.addr_i[ADDR_W-1:2];
  assign load_idx_c       = bus.load_addr_i[ADDR_W-1:2];
  assign fetch_in_range_c = {1'b0, fetch_idx_c} < DEPTH_EXT;
  assign load_in_range_c  = {1'b0, load_idx_c} < DEPTH_EXT;

  assign fault_c = (bus.addr_i[1:0] != 2'b00) ? 2'b01 :
                   (!fetch_in_range_c)        ? 2'b10 : 2'b00;

  assign ready_c  = !bus.load_en_i && !bus.flush_i &&
                    ((state_q == EMPTY) || bus.rsp_ready_i);
  assign accept_c = bus.req_valid_i && ready_c;

  assign bus.req_ready_o = ready_c;
  assign bus.rsp_valid_o = (state_q == FULL);
  assign bus.instr_o     = instr_q;
  assign bus.fault_o     = fault_q;
  assign bus.fetch_cnt_o = cnt_q;

  // Program-load write port; out-of-range loads are dropped.
  always_ff @(posedge clk_i) begin
    if (bus.load_en_i && load_in_range_c) begin
      mem[load_idx_c[IDX_W-1:0]] <= bus.load_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush blocks acceptance via ready_c, so accept_c is already low on flush.
  always_comb begin
    state_d    = state_q;
    load_rsp_c = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept_c) begin
          state_d    = FULL;
          load_rsp_c = 1'b1;
        end
      end
      FULL: begin
        if (bus.flush_i) begin
          state_d = EMPTY;
        end else if (bus.rsp_ready_i) begin
          if (accept_c) begin
            load_rsp_c = 1'b1;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Response payload and fetch counter; payload is held when not reloaded.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      instr_q <= NOP_INSTR;
      fault_q <= 2'b00;
      cnt_q   <= 32'd0;
    end else begin
      if (load_rsp_c) begin
        instr_q <= (fault_c == 2'b00) ? mem[fetch_idx_c[IDX_W-1:0]] : NOP_INSTR;
        fault_q <= fault_c;
      end
      if (accept_c) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_instr_mem_pipe.sv
// Scoreboard bench for instr_mem_pipe: a reference model predicts each response at
// acceptance and compares it when the response is consumed.
module tb_instr_mem_pipe;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = 32;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [1:0]  fault;
  } rsp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_mem_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  instr_mem_pipe #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP_INSTR(NOP)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  rsp_t        exp_q[$];
  logic [31:0] mmem [DEPTH];
  logic        m_full = 1'b0;
  logic [31:0] m_cnt  = 32'd0;
  logic        mon_rdy, mon_acc;
  rsp_t        mon_r;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic rsp_t model_fetch(input logic [31:0] a);
    rsp_t r;
    if (a[1:0] != 2'b00) begin
      r.instr = NOP; r.fault = 2'b01;
    end else if (a[31:2] >= 30'(DEPTH)) begin
      r.instr = NOP; r.fault = 2'b10;
    end else begin
      r.instr = mmem[int'(a[31:2])]; r.fault = 2'b00;
    end
    return r;
  endfunction

  // Reference model: observes pre-edge inputs and predicts handshake, data and count.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_full = 1'b0;
      m_cnt  = 32'd0;
    end else begin
      mon_rdy = !bus.load_en_i && !bus.flush_i && (!m_full || bus.rsp_ready_i);
      check_eq("req_ready", 64'(bus.req_ready_o), 64'(mon_rdy));
      check_eq("rsp_valid", 64'(bus.rsp_valid_o), 64'(m_full));
      check_eq("fetch_cnt", 64'(bus.fetch_cnt_o), 64'(m_cnt));
      mon_acc = bus.req_valid_i && mon_rdy;
      if (m_full && bus.flush_i) begin
        void'(exp_q.pop_front());
        m_full = 1'b0;
      end else if (m_full && bus.rsp_ready_i) begin
        mon_r = exp_q.pop_front();
        check_eq("rsp_instr", 64'(bus.instr_o), 64'(mon_r.instr));
        check_eq("rsp_fault", 64'(bus.fault_o), 64'(mon_r.fault));
        m_full = 1'b0;
      end
      if (mon_acc) begin
        exp_q.push_back(model_fetch(bus.addr_i));
        m_full = 1'b1;
        m_cnt  = m_cnt + 32'd1;
      end
      if (bus.load_en_i && (bus.load_addr_i[31:2] < 30'(DEPTH))) begin
        mmem[int'(bus.load_addr_i[31:2])] = bus.load_data_i;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rsp_valid"}, 64'(bus.rsp_valid_o), 64'd0);
    check_eq({tag, "_instr"},     64'(bus.instr_o),     64'(NOP));
    check_eq({tag, "_fault"},     64'(bus.fault_o),     64'd0);
    check_eq({tag, "_cnt"},       64'(bus.fetch_cnt_o), 64'd0);
  endtask

  task automatic async_reset_in_full(input logic [31:0] a);
    @(negedge clk);
    bus.rsp_ready_i = 1'b0; bus.req_valid_i = 1'b1; bus.addr_i = a;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    #1 check_eq("pre_rst_full", 64'(bus.rsp_valid_o), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fetch_burst(input logic [31:0] a0, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.req_valid_i = 1'b1; bus.addr_i = a0 + 32'(4 * i);
    end
    @(negedge clk);
    bus.req_valid_i = 1'b0;
  endtask

  logic [31:0] fault_addr [3];

  initial begin
    bus.req_valid_i = 1'b0; bus.addr_i = '0; bus.rsp_ready_i = 1'b0; bus.flush_i = 1'b0;
    bus.load_en_i = 1'b0; bus.load_addr_i = '0; bus.load_data_i = '0;
    fault_addr[0] = 32'd6;
    fault_addr[1] = 32'(4 * DEPTH);
    fault_addr[2] = 32'(4 * DEPTH + 2);

    #12 check_reset_outputs("init_rst");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.load_en_i = 1'b1; bus.load_addr_i = 32'(4 * i); bus.load_data_i = 32'h1111_0000 + 32'(i);
    end
    @(negedge clk);
    bus.load_en_i = 1'b0; bus.rsp_ready_i = 1'b1;

    // Back-to-back fetch of words 0..3.
    fetch_burst(32'd0, 4);
    @(negedge clk);
    #1 check_eq("burst_cnt", 64'(bus.fetch_cnt_o), 64'd4);

    // Back-pressure: word 0 held while word 1 waits.
    @(negedge clk);
    bus.rsp_ready_i = 1'b0; bus.req_valid_i = 1'b1; bus.addr_i = 32'd0;
    @(negedge clk);
    bus.addr_i = 32'd4;
    for (int i = 0; i < 3; i++) begin
      #1 check_eq("bp_ready", 64'(bus.req_ready_o), 64'd0);
      check_eq("bp_hold", 64'(bus.instr_o), 64'h1111_0000);
      @(negedge clk);
    end
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    #1 check_eq("bp_next", 64'(bus.instr_o), 64'h1111_0001);

    // Faulted fetches.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.req_valid_i = 1'b1; bus.addr_i = fault_addr[i];
    end
    @(negedge clk);
    bus.req_valid_i = 1'b0;

    // Flush while FULL and stalled.
    @(negedge clk);
    bus.rsp_ready_i = 1'b0; bus.req_valid_i = 1'b1; bus.addr_i = 32'd0;
    @(negedge clk);
    bus.addr_i = 32'd4; bus.flush_i = 1'b1;
    #1 check_eq("flush_ready", 64'(bus.req_ready_o), 64'd0);
    check_eq("flush_cnt", 64'(bus.fetch_cnt_o), 64'd10);
    @(negedge clk);
    bus.flush_i = 1'b0; bus.req_valid_i = 1'b0;
    #1 check_eq("flush_valid", 64'(bus.rsp_valid_o), 64'd0);
    check_eq("flush_cnt_after", 64'(bus.fetch_cnt_o), 64'd10);

    // Load blocks a pending request; next-cycle fetch sees the new word.
    @(negedge clk);
    bus.rsp_ready_i = 1'b1; bus.load_en_i = 1'b1; bus.load_addr_i = 32'd8;
    bus.load_data_i = 32'hDEAD_BEEF; bus.req_valid_i = 1'b1; bus.addr_i = 32'd8;
    #1 check_eq("load_ready", 64'(bus.req_ready_o), 64'd0);
    @(negedge clk);
    bus.load_en_i = 1'b0;
    // Out-of-range load, issued while the DEADBEEF response drains.
    @(negedge clk);
    bus.req_valid_i = 1'b0; bus.load_en_i = 1'b1;
    bus.load_addr_i = 32'(4 * DEPTH); bus.load_data_i = 32'hBAD0_BAD0;
    @(negedge clk);
    bus.load_en_i = 1'b0;
    fetch_burst(32'd0, 4);

    // Asynchronous reset in FULL, once with a good word and once with a fault held.
    async_reset_in_full(32'd4);
    async_reset_in_full(32'd6);

    bus.rsp_ready_i = 1'b1;
    fetch_burst(32'd0, 3);
    @(negedge clk);
    @(negedge clk);
    #1 check_eq("post_rst_cnt", 64'(bus.fetch_cnt_o), 64'd3);
    check_eq("post_rst_idle", 64'(bus.rsp_valid_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
